// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Arbitrates the single register-file write port between the pipeline
// writeback (P) and a multicycle unit writeback (M).  P normally has priority;
// when M has been held off for STARVE_MAX consecutive cycles the arbiter enters
// FORCE for one cycle, stalls P and grants M.  A pending-write scoreboard
// tracks destinations of issued multicycle ops so that hazard queries can see
// registers that are not yet readable from the register file.
//
// Ports
//   clk                  clock, all state updates on rising edge
//   rst                  asynchronous, active-low reset
//   p_valid/p_wa/p_wd    pipeline writeback request
//   p_stall              P must hold its writeback this cycle
//   m_valid/m_wa/m_wd    multicycle-unit writeback request
//   m_ready              M transfer completes on m_valid & m_ready at clk edge
//   iss_valid/iss_wa     multicycle op issued, iss_wa becomes pending
//   q_a/q_b              hazard-query register addresses
//   q_a_busy/q_b_busy    queried register not yet readable from the RF
//   rf_we/rf_wa/rf_wd    registered register-file write port
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 32'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_valid,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    output logic        p_stall,
    input  logic        m_valid,
    input  logic [4:0]  m_wa,
    input  logic [31:0] m_wd,
    output logic        m_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wa,
    input  logic [4:0]  q_a,
    input  logic [4:0]  q_b,
    output logic        q_a_busy,
    output logic        q_b_busy,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] pend_q, pend_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_wa_q, rf_wa_d;
    logic [31:0] rf_wd_q, rf_wd_d;

    logic        grant_p_s;
    logic        grant_m_s;
    logic        stall_s;

    // Grant decision; everything is gated off while reset is asserted so the
    // handshake outputs read 0 during reset regardless of request inputs.
    always_comb begin
        grant_p_s = 1'b0;
        grant_m_s = 1'b0;
        stall_s   = 1'b0;
        if (!rst) begin
            grant_p_s = 1'b0;
            grant_m_s = 1'b0;
            stall_s   = 1'b0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (p_valid) begin
                        grant_p_s = 1'b1;
                    end else begin
                        grant_m_s = m_valid;
                    end
                end
                ST_FORCE: begin
                    // m_valid low here is a protocol violation: nothing granted
                    grant_m_s = m_valid;
                    stall_s   = p_valid;
                end
                default: begin
                    grant_p_s = 1'b0;
                    grant_m_s = 1'b0;
                    stall_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM next state and starvation counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (m_valid && !grant_m_s) begin
                    wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : (wait_cnt_q + 4'd1);
                    // Enter FORCE on the edge where the count reaches the limit
                    if (wait_cnt_d >= STARVE_LIM) begin
                        state_d = ST_FORCE;
                    end else begin
                        state_d = ST_NORMAL;
                    end
                end else begin
                    wait_cnt_d = 4'd0;
                    state_d    = ST_NORMAL;
                end
            end
            ST_FORCE: begin
                wait_cnt_d = 4'd0;
                state_d    = ST_NORMAL;
            end
            default: begin
                wait_cnt_d = 4'd0;
                state_d    = ST_NORMAL;
            end
        endcase
    end

    // Register-file write port next value; a write to r0 still completes the
    // grant but never asserts the write enable.
    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (grant_p_s) begin
            rf_we_d = (p_wa != 5'd0);
            rf_wa_d = p_wa;
            rf_wd_d = p_wd;
        end else if (grant_m_s) begin
            rf_we_d = (m_wa != 5'd0);
            rf_wa_d = m_wa;
            rf_wd_d = m_wd;
        end else begin
            rf_we_d = 1'b0;
        end
    end

    // Scoreboard update; the issue-side set is applied last so it wins over a
    // same-cycle clear of the same register.
    always_comb begin
        pend_d = pend_q;
        if (grant_m_s) begin
            pend_d[m_wa] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (iss_valid && (iss_wa != 5'd0)) begin
            pend_d[iss_wa] = 1'b1;
        end else begin
            pend_d[0] = 1'b0;
        end
        pend_d[0] = 1'b0;
    end

    // All state, including the registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_NORMAL;
            wait_cnt_q <= 4'd0;
            pend_q     <= 32'd0;
            rf_we_q    <= 1'b0;
            rf_wa_q    <= 5'd0;
            rf_wd_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            rf_we_q    <= rf_we_d;
            rf_wa_q    <= rf_wa_d;
            rf_wd_q    <= rf_wd_d;
        end
    end

    // Hazard queries: a register stays busy through the cycle its write is
    // on the RF port, since the RF only holds the value after that edge.
    always_comb begin
        q_a_busy = 1'b0;
        q_b_busy = 1'b0;
        if (rst) begin
            q_a_busy = pend_q[q_a] | (rf_we_q & (rf_wa_q == q_a) & (q_a != 5'd0));
            q_b_busy = pend_q[q_b] | (rf_we_q & (rf_wa_q == q_b) & (q_b != 5'd0));
        end else begin
            q_a_busy = 1'b0;
            q_b_busy = 1'b0;
        end
    end

    assign m_ready = grant_m_s;
    assign p_stall = stall_s;
    assign rf_we   = rf_we_q;
    assign rf_wa   = rf_wa_q;
    assign rf_wd   = rf_wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed-vector bench for rf_wb_arbiter with STARVE_MAX = 3.  Inputs change
// 1 ns after the rising edge; outputs are sampled 1 ns later, well away from
// the next edge.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        p_valid;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        p_stall;
    logic        m_valid;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_ready;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic [4:0]  q_a;
    logic [4:0]  q_b;
    logic        q_a_busy;
    logic        q_b_busy;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int n_vec;
    int n_err;

    rf_wb_arbiter #(.STARVE_MAX(32'd3)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_wa      (p_wa),
        .p_wd      (p_wd),
        .p_stall   (p_stall),
        .m_valid   (m_valid),
        .m_wa      (m_wa),
        .m_wd      (m_wd),
        .m_ready   (m_ready),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .q_a       (q_a),
        .q_b       (q_b),
        .q_a_busy  (q_a_busy),
        .q_b_busy  (q_b_busy),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_valid   = 1'b0;
        p_wa      = 5'd0;
        p_wd      = 32'd0;
        m_valid   = 1'b0;
        m_wa      = 5'd0;
        m_wd      = 32'd0;
        iss_valid = 1'b0;
        iss_wa    = 5'd0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        idle_inputs();
        q_a   = 5'd0;
        q_b   = 5'd3;

        // ---- reset state, with an M request present -------------------------
        m_valid = 1'b1;
        m_wa    = 5'd6;
        #3;
        check_vec("rst_m_ready", {31'd0, m_ready}, 32'd0);
        check_vec("rst_p_stall", {31'd0, p_stall}, 32'd0);
        check_vec("rst_rf_we",   {31'd0, rf_we},   32'd0);
        check_vec("rst_rf_wa",   {27'd0, rf_wa},   32'd0);
        check_vec("rst_rf_wd",   rf_wd,            32'd0);
        tick();
        m_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // ---- P only --------------------------------------------------------
        p_valid = 1'b1;
        p_wa    = 5'd5;
        p_wd    = 32'hDEADBEEF;
        #1;
        check_vec("p_only_stall", {31'd0, p_stall}, 32'd0);
        check_vec("p_only_mrdy",  {31'd0, m_ready}, 32'd0);
        tick();
        idle_inputs();
        check_vec("p_only_we", {31'd0, rf_we}, 32'd1);
        check_vec("p_only_wa", {27'd0, rf_wa}, 32'd5);
        check_vec("p_only_wd", rf_wd,          32'hDEADBEEF);
        tick();
        check_vec("idle_we",   {31'd0, rf_we}, 32'd0);
        check_vec("idle_hold", {27'd0, rf_wa}, 32'd5);

        // ---- P and M together: starvation then forced grant ----------------
        p_valid = 1'b1;
        p_wa    = 5'd1;
        p_wd    = 32'h11111111;
        m_valid = 1'b1;
        m_wa    = 5'd2;
        m_wd    = 32'h22222222;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_vec($sformatf("starve%0d_mrdy", i),  {31'd0, m_ready}, 32'd0);
            check_vec($sformatf("starve%0d_stall", i), {31'd0, p_stall}, 32'd0);
            tick();
            check_vec($sformatf("starve%0d_rfwa", i),  {27'd0, rf_wa},   32'd1);
        end
        check_vec("force_mrdy",  {31'd0, m_ready}, 32'd1);
        check_vec("force_stall", {31'd0, p_stall}, 32'd1);
        tick();
        m_valid = 1'b0;
        #1;
        check_vec("force_rf_we", {31'd0, rf_we}, 32'd1);
        check_vec("force_rf_wa", {27'd0, rf_wa}, 32'd2);
        check_vec("force_rf_wd", rf_wd,          32'h22222222);
        check_vec("after_force_stall", {31'd0, p_stall}, 32'd0);
        tick();
        idle_inputs();
        check_vec("p_resume_wa", {27'd0, rf_wa}, 32'd1);
        check_vec("p_resume_wd", rf_wd,          32'h11111111);
        tick();

        // ---- scoreboard: issue r7, M writes r7 -----------------------------
        iss_valid = 1'b1;
        iss_wa    = 5'd7;
        q_a       = 5'd7;
        #1;
        check_vec("sb_pre_busy", {31'd0, q_a_busy}, 32'd0);
        tick();
        iss_valid = 1'b0;
        check_vec("sb_pend_busy", {31'd0, q_a_busy}, 32'd1);
        check_vec("sb_qb_free",   {31'd0, q_b_busy}, 32'd0);
        tick();
        check_vec("sb_hold_busy", {31'd0, q_a_busy}, 32'd1);
        m_valid = 1'b1;
        m_wa    = 5'd7;
        m_wd    = 32'h77777777;
        #1;
        check_vec("sb_m_rdy", {31'd0, m_ready}, 32'd1);
        tick();
        m_valid = 1'b0;
        #1;
        check_vec("sb_wr_we",   {31'd0, rf_we},    32'd1);
        check_vec("sb_wr_wa",   {27'd0, rf_wa},    32'd7);
        check_vec("sb_wr_busy", {31'd0, q_a_busy}, 32'd1);
        tick();
        check_vec("sb_free", {31'd0, q_a_busy}, 32'd0);

        // ---- M write to r0 -------------------------------------------------
        m_valid = 1'b1;
        m_wa    = 5'd0;
        m_wd    = 32'hAAAA5555;
        q_a     = 5'd0;
        #1;
        check_vec("r0_mrdy", {31'd0, m_ready}, 32'd1);
        tick();
        m_valid = 1'b0;
        #1;
        check_vec("r0_we",   {31'd0, rf_we},    32'd0);
        check_vec("r0_wd",   rf_wd,             32'hAAAA5555);
        check_vec("r0_busy", {31'd0, q_a_busy}, 32'd0);
        tick();

        // ---- same-cycle set and clear of r9 --------------------------------
        iss_valid = 1'b1;
        iss_wa    = 5'd9;
        q_a       = 5'd9;
        tick();
        m_valid = 1'b1;
        m_wa    = 5'd9;
        m_wd    = 32'h99999999;
        #1;
        check_vec("r9_mrdy", {31'd0, m_ready}, 32'd1);
        tick();
        idle_inputs();
        tick();
        check_vec("r9_rf_we",   {31'd0, rf_we},    32'd0);
        check_vec("r9_pending", {31'd0, q_a_busy}, 32'd1);

        // ---- reset asserted mid-FORCE with pend[9] set ---------------------
        p_valid = 1'b1;
        p_wa    = 5'd1;
        p_wd    = 32'h11111111;
        m_valid = 1'b1;
        m_wa    = 5'd4;
        m_wd    = 32'h44444444;
        q_b     = 5'd1;
        tick();
        tick();
        tick();
        check_vec("rf_force_mrdy", {31'd0, m_ready}, 32'd1);
        rst = 1'b0;
        #1;
        check_vec("rf_rst_mrdy",  {31'd0, m_ready},  32'd0);
        check_vec("rf_rst_stall", {31'd0, p_stall},  32'd0);
        check_vec("rf_rst_abusy", {31'd0, q_a_busy}, 32'd0);
        check_vec("rf_rst_bbusy", {31'd0, q_b_busy}, 32'd0);
        check_vec("rf_rst_we",    {31'd0, rf_we},    32'd0);
        check_vec("rf_rst_wa",    {27'd0, rf_wa},    32'd0);
        check_vec("rf_rst_wd",    rf_wd,             32'd0);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        check_vec("rel_we",    {31'd0, rf_we},    32'd0);
        check_vec("rel_wa",    {27'd0, rf_wa},    32'd0);
        check_vec("rel_wd",    rf_wd,             32'd0);
        check_vec("rel_abusy", {31'd0, q_a_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive cycles M may wait before forced grant, legal range 1..15.
REQ-002 SHALL have port clk, in, 1: clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, in, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports p_valid in 1, p_wa in 5, p_wd in 32: pipeline writeback request (P).
REQ-005 SHALL have port p_stall, out, 1: P must hold its writeback this cycle.
REQ-006 SHALL have ports m_valid in 1, m_wa in 5, m_wd in 32: multicycle-unit writeback request (M).
REQ-007 SHALL have port m_ready, out, 1: M transfer completes when m_valid and m_ready are both high at posedge clk.
REQ-008 SHALL have ports iss_valid in 1, iss_wa in 5: multicycle op issued; iss_wa becomes pending.
REQ-009 SHALL have ports q_a in 5, q_b in 5: hazard-query read addresses.
REQ-010 SHALL have ports q_a_busy out 1, q_b_busy out 1: queried register not yet readable from register file.
REQ-011 SHALL have ports rf_we out 1, rf_wa out 5, rf_wd out 32: single register-file write port, registered.

Function
REQ-012 SHALL grant at most one requester per cycle.
REQ-013 SHALL implement states NORMAL and FORCE in a two-state FSM.
REQ-014 In NORMAL SHALL grant P if p_valid, else M if m_valid, else none.
REQ-015 SHALL drive m_ready combinationally high exactly when M is granted.
REQ-016 SHALL drive p_stall combinationally high only in FORCE with p_valid high; p_stall SHALL be 0 in NORMAL.
REQ-017 SHALL keep 4-bit wait_cnt: increment when m_valid and not m_ready, clear on M transfer or m_valid low.
REQ-018 SHALL move NORMAL->FORCE at the edge where wait_cnt reaches STARVE_MAX with m_valid high.
REQ-019 In FORCE SHALL grant M unconditionally and return to NORMAL next edge, clearing wait_cnt.
REQ-020 If m_valid is low in FORCE (protocol violation) SHALL grant none and return to NORMAL.
REQ-021 M must hold m_valid, m_wa, m_wd stable until transfer; P holds while p_stall is high.
REQ-022 On a grant SHALL load rf_wa/rf_wd with granted address/data at the next edge: one-cycle latency.
REQ-023 SHALL set rf_we to 1 at that edge, except rf_we=0 when granted address is 0; the grant/handshake still completes.
REQ-024 With no grant SHALL set rf_we=0 and hold rf_wa/rf_wd.
REQ-025 SHALL keep scoreboard pend[31:1]; pend[0] is constant 0.
REQ-026 SHALL set pend[iss_wa] on iss_valid when iss_wa!=0.
REQ-027 SHALL clear pend[m_wa] on M transfer.
REQ-028 On same-cycle set and clear of one register, set SHALL win.
REQ-029 P writes SHALL NOT modify pend.
REQ-030 q_x_busy SHALL = pend[q_x] OR (rf_we AND rf_wa==q_x AND q_x!=0), combinational.

Reset
REQ-031 On rst low SHALL immediately force: state NORMAL, wait_cnt 0, pend all 0, rf_we 0, rf_wa 0, rf_wd 0.
REQ-032 While rst is low SHALL drive m_ready 0, p_stall 0, q_a_busy 0 and q_b_busy 0.
REQ-033 An M transfer in flight at reset SHALL be dropped without a write.
REQ-034 SHALL resume arbitration at the first posedge after rst deasserts.

Verification
REQ-035 Bench SHALL apply P only (wa=5, wd=0xDEADBEEF) -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF one cycle later; p_stall=0.
REQ-036 Bench SHALL apply P and M valid together each cycle with STARVE_MAX=3 -> M waits 3 cycles, 4th cycle m_ready=1 and p_stall=1, M data on rf next cycle, then P resumes.
REQ-037 Bench SHALL issue iss_wa=7, query q_a=7 -> q_a_busy=1 until M writes reg 7; busy stays high through the rf_we cycle and drops the cycle after.
REQ-038 Bench SHALL apply M write to wa=0 -> m_ready=1 handshake completes and rf_we remains 0.
REQ-039 Bench SHALL apply iss_valid wa=9 in the same cycle as M transfer wa=9 -> pend[9] remains 1.
REQ-040 Bench SHALL assert rst low mid-FORCE with pend nonzero -> all outputs 0 immediately, with no write after release.
